mem_responder: RTL and testbench

Single-port word memory that answers the LC-3b core's memory request interface: it accepts `mem_read`/`mem_write` with address, write data and byte mask, waits a programmable number of cycles, then performs the access and pulses `mem_resp`. It sits at the top level beside `mp1` and drives that core's memory inputs. It serves both as a synthesizable on-chip RAM and as the bench's memory model with adjustable latency.

---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 151 +++++++++++++++
 tb/tb_mem_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the LC-3b core and its word memory.
// The core drives the request side; the memory drives the response side.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;
    logic [15:0] mem_rdata;

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        output mem_byte_enable,
        input  mem_resp,
        input  mem_rdata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        input  mem_byte_enable,
        output mem_resp,
        output mem_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port 16-bit word memory with programmable response latency,
// answering the LC-3b memory request bus with a one-cycle mem_resp pulse.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus,
    output logic            proto_err,
    output logic [15:0]     rd_count,
    output logic [15:0]     wr_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic [3:0]          cnt_r;
    logic                op_read_r;
    logic [ADDR_W-1:0]   idx_r;
    logic [15:0]         wdata_r;
    logic [1:0]          be_r;
    logic                resp_r;
    logic [15:0]         rdata_r;
    logic                proto_err_r;
    logic [15:0]         rd_count_r;
    logic [15:0]         wr_count_r;

    logic [15:0]         mem_r [DEPTH];

    logic                req_s;
    logic                hold_s;
    logic [ADDR_W-1:0]   accept_idx_s;
    logic                unused_addr_s;

    // Request decode: acceptance in IDLE, and the hold check for the latched op.
    always_comb begin
        req_s        = 1'b0;
        hold_s       = 1'b0;
        accept_idx_s = bus.mem_address[ADDR_W:1];
        if (bus.mem_read || bus.mem_write) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        if (op_read_r) begin
            hold_s = bus.mem_read;
        end else begin
            hold_s = bus.mem_write;
        end
    end

    // Upper address bits alias onto the word index and bit 0 is a byte offset.
    assign unused_addr_s = ^bus.mem_address;

    // Transaction FSM with all externally visible outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            op_read_r   <= 1'b0;
            idx_r       <= '0;
            wdata_r     <= 16'h0000;
            be_r        <= 2'b00;
            resp_r      <= 1'b0;
            rdata_r     <= 16'h0000;
            proto_err_r <= 1'b0;
            rd_count_r  <= 16'd0;
            wr_count_r  <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_r <= 1'b0;
                    if (req_s) begin
                        op_read_r <= bus.mem_read;
                        idx_r     <= accept_idx_s;
                        wdata_r   <= bus.mem_wdata;
                        be_r      <= bus.mem_byte_enable;
                        cnt_r     <= CNT_LOAD;
                        if (bus.mem_read && bus.mem_write) begin
                            proto_err_r <= 1'b1;
                        end
                        if (LATENCY == 1) begin
                            // Zero BUSY cycles: the read data is fetched on acceptance.
                            state_r <= RESP;
                            resp_r  <= 1'b1;
                            if (bus.mem_read) begin
                                rdata_r <= mem_r[accept_idx_s];
                            end
                        end else begin
                            state_r <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!hold_s) begin
                        state_r <= IDLE;
                    end else if (cnt_r == 4'd1) begin
                        state_r <= RESP;
                        resp_r  <= 1'b1;
                        cnt_r   <= 4'd0;
                        if (op_read_r) begin
                            rdata_r <= mem_r[idx_r];
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    resp_r  <= 1'b0;
                    state_r <= IDLE;
                    if (op_read_r) begin
                        rd_count_r <= rd_count_r + 16'd1;
                    end else begin
                        wr_count_r <= wr_count_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    resp_r  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: not reset; a write lands on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if ((state_r == RESP) && !op_read_r) begin
            if (be_r[0]) begin
                mem_r[idx_r][7:0] <= wdata_r[7:0];
            end
            if (be_r[1]) begin
                mem_r[idx_r][15:8] <= wdata_r[15:8];
            end
        end
    end

    assign bus.mem_resp  = resp_r;
    assign bus.mem_rdata = rdata_r;
    assign proto_err     = proto_err_r;
    assign rd_count      = rd_count_r;
    assign wr_count      = wr_count_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances at LATENCY 1, 2 and 4
// share one stimulus bundle, steered to the instance under test by sel.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;

    logic        cur_resp;
    logic [15:0] cur_rdata;
    logic        cur_perr;
    logic [15:0] cur_rdc;
    logic [15:0] cur_wrc;

    int checks;
    int errors;

    mem_responder_if if1 ();
    mem_responder_if if2 ();
    mem_responder_if if4 ();

    logic        perr1, perr2, perr4;
    logic [15:0] rdc1, rdc2, rdc4, wrc1, wrc2, wrc4;

    assign if1.mem_read = (sel == 2'd1) & rd;
    assign if1.mem_write = (sel == 2'd1) & wr;
    assign if1.mem_address = addr;
    assign if1.mem_wdata = wdata;
    assign if1.mem_byte_enable = be;
    assign if2.mem_read = (sel == 2'd2) & rd;
    assign if2.mem_write = (sel == 2'd2) & wr;
    assign if2.mem_address = addr;
    assign if2.mem_wdata = wdata;
    assign if2.mem_byte_enable = be;
    assign if4.mem_read = (sel == 2'd3) & rd;
    assign if4.mem_write = (sel == 2'd3) & wr;
    assign if4.mem_address = addr;
    assign if4.mem_wdata = wdata;
    assign if4.mem_byte_enable = be;

    mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1),
        .proto_err(perr1), .rd_count(rdc1), .wr_count(wrc1));
    mem_responder #(.ADDR_W(8), .LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2),
        .proto_err(perr2), .rd_count(rdc2), .wr_count(wrc2));
    mem_responder #(.ADDR_W(8), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4),
        .proto_err(perr4), .rd_count(rdc4), .wr_count(wrc4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe the outputs of the selected instance (sel 3 = LATENCY 4).
    always_comb begin
        case (sel)
            2'd1: begin
                cur_resp = if1.mem_resp; cur_rdata = if1.mem_rdata;
                cur_perr = perr1; cur_rdc = rdc1; cur_wrc = wrc1;
            end
            2'd3: begin
                cur_resp = if4.mem_resp; cur_rdata = if4.mem_rdata;
                cur_perr = perr4; cur_rdc = rdc4; cur_wrc = wrc4;
            end
            default: begin
                cur_resp = if2.mem_resp; cur_rdata = if2.mem_rdata;
                cur_perr = perr2; cur_rdc = rdc2; cur_wrc = wrc2;
            end
        endcase
    end

    typedef struct {
        logic [1:0]  sel;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          exp_cyc;
        logic [15:0] exp_rdata;
        logic [15:0] exp_rdc;
        logic [15:0] exp_wrc;
        logic        exp_perr;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request in the current cycle, wait for mem_resp, return to IDLE.
    task automatic access(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] b,
                          output int cyc, output logic [15:0] rdat);
        cyc  = 0;
        rdat = 16'h0000;
        rd = r; wr = w; addr = a; wdata = d; be = b;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (cur_resp) begin
                cyc  = n;
                rdat = cur_rdata;
                break;
            end
        end
        rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
    endtask

    int          cyc;
    logic [15:0] rdat;
    logic        seen;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; sel = 2'd0; rd = 1'b0; wr = 1'b0;
        addr = 16'h0000; wdata = 16'h0000; be = 2'b00;

        vecs[0]  = '{2'd2, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 2, 16'h0000, 16'd0, 16'd1, 1'b0};
        vecs[1]  = '{2'd2, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 2, 16'hBEEF, 16'd1, 16'd1, 1'b0};
        vecs[2]  = '{2'd2, 1'b0, 1'b1, 16'h0004, 16'h1234, 2'b11, 2, 16'hBEEF, 16'd1, 16'd2, 1'b0};
        vecs[3]  = '{2'd2, 1'b0, 1'b1, 16'h0004, 16'hAB00, 2'b10, 2, 16'hBEEF, 16'd1, 16'd3, 1'b0};
        vecs[4]  = '{2'd2, 1'b0, 1'b1, 16'h0004, 16'h00CD, 2'b01, 2, 16'hBEEF, 16'd1, 16'd4, 1'b0};
        vecs[5]  = '{2'd2, 1'b1, 1'b0, 16'h0004, 16'h0000, 2'b00, 2, 16'hABCD, 16'd2, 16'd4, 1'b0};
        vecs[6]  = '{2'd2, 1'b1, 1'b0, 16'h0005, 16'h0000, 2'b00, 2, 16'hABCD, 16'd3, 16'd4, 1'b0};
        vecs[7]  = '{2'd2, 1'b0, 1'b1, 16'h0004, 16'hFFFF, 2'b00, 2, 16'hABCD, 16'd3, 16'd5, 1'b0};
        vecs[8]  = '{2'd2, 1'b1, 1'b0, 16'h0204, 16'h0000, 2'b00, 2, 16'hABCD, 16'd4, 16'd5, 1'b0};
        vecs[9]  = '{2'd2, 1'b1, 1'b1, 16'h0010, 16'h5555, 2'b11, 2, 16'hBEEF, 16'd5, 16'd5, 1'b1};
        vecs[10] = '{2'd2, 1'b0, 1'b1, 16'h0010, 16'h1111, 2'b11, 2, 16'hBEEF, 16'd5, 16'd6, 1'b1};
        vecs[11] = '{2'd2, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 2, 16'h1111, 16'd6, 16'd6, 1'b1};
        vecs[12] = '{2'd1, 1'b0, 1'b1, 16'h0020, 16'h00A5, 2'b11, 1, 16'h0000, 16'd0, 16'd1, 1'b0};
        vecs[13] = '{2'd1, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1, 16'h00A5, 16'd1, 16'd1, 1'b0};
        vecs[14] = '{2'd3, 1'b0, 1'b1, 16'h0030, 16'h4444, 2'b11, 4, 16'h0000, 16'd0, 16'd1, 1'b0};
        vecs[15] = '{2'd3, 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 4, 16'h4444, 16'd1, 16'd1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        for (int s = 1; s <= 3; s++) begin
            sel = 2'(s);
            #1;
            chk("reset_resp", {31'd0, cur_resp}, 32'd0);
            chk("reset_rdata", {16'd0, cur_rdata}, 32'd0);
            chk("reset_perr", {31'd0, cur_perr}, 32'd0);
            chk("reset_counts", {cur_rdc, cur_wrc}, 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            sel = vecs[i].sel;
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, cyc, rdat);
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_rdata", i), {16'd0, rdat}, {16'd0, vecs[i].exp_rdata});
            chk($sformatf("v%0d_rd_count", i), {16'd0, cur_rdc}, {16'd0, vecs[i].exp_rdc});
            chk($sformatf("v%0d_wr_count", i), {16'd0, cur_wrc}, {16'd0, vecs[i].exp_wrc});
            chk($sformatf("v%0d_proto_err", i), {31'd0, cur_perr}, {31'd0, vecs[i].exp_perr});
        end

        // Held read at LATENCY 1: responses every other cycle.
        sel = 2'd1;
        rd = 1'b1; wr = 1'b0; addr = 16'h0020;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("held_resp_c%0d", k), {31'd0, cur_resp}, {31'd0, 1'(k % 2)});
        end
        rd = 1'b0;
        @(posedge clk); #1;
        chk("held_resp_c6", {31'd0, cur_resp}, 32'd0);
        chk("held_rd_count", {16'd0, cur_rdc}, 32'd4);
        chk("held_rdata", {16'd0, cur_rdata}, 32'h00A5);

        // Abort at LATENCY 4: write dropped in cycle 2.
        sel = 2'd3;
        wr = 1'b1; rd = 1'b0; addr = 16'h0030; wdata = 16'h9999; be = 2'b11;
        seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (cur_resp) seen = 1'b1;
            if (k == 2) wr = 1'b0;
        end
        chk("abort_no_resp", {31'd0, seen}, 32'd0);
        chk("abort_wr_count", {16'd0, cur_wrc}, 32'd1);
        access(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, cyc, rdat);
        chk("abort_read_latency", 32'(cyc), 32'd4);
        chk("abort_read_data", {16'd0, rdat}, 32'h4444);

        // Reset during BUSY of a write at LATENCY 2.
        sel = 2'd2;
        wr = 1'b1; rd = 1'b0; addr = 16'h0010; wdata = 16'h7777; be = 2'b11;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_resp", {31'd0, cur_resp}, 32'd0);
        chk("rst_counts", {cur_rdc, cur_wrc}, 32'd0);
        chk("rst_perr", {31'd0, cur_perr}, 32'd0);
        chk("rst_rdata", {16'd0, cur_rdata}, 32'd0);
        wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, cyc, rdat);
        chk("post_rst_latency", 32'(cyc), 32'd2);
        chk("post_rst_data", {16'd0, rdat}, 32'h1111);
        chk("post_rst_counts", {cur_rdc, cur_wrc}, {16'd1, 16'd0});
        chk("post_rst_perr", {31'd0, cur_perr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
